// File: rtl/util_pkg.sv
// Shared types and default sizing for the ROB commit controller.
// Entry layout and recovery FSM encoding live here so the top and the entry table agree.
package util_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int RHT_DEPTH = 8;

  typedef struct packed {
    logic                         valid;
    logic                         done;
    logic                         mispred;
    logic                         br;
    logic [$clog2(RHT_DEPTH)-1:0] rht_id;
  } rob_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    REC_REQ,
    REC_WAIT,
    FLUSH
  } rec_state_t;

endpackage

// File: rtl/rob_entry_table.sv
// ROB entry storage: one write port each for allocation, execution completion,
// retirement and a bulk flush, plus combinational read of the head and the completing entry.
module rob_entry_table #(
  parameter int ROB_DEPTH = util_pkg::ROB_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   alloc_we,
  input  logic [$clog2(ROB_DEPTH)-1:0]           alloc_idx,
  input  util_pkg::rob_entry_t                   alloc_entry,
  input  logic                                   ex_we,
  input  logic [$clog2(ROB_DEPTH)-1:0]           ex_idx,
  input  logic                                   ex_mispred,
  input  logic                                   retire_we,
  input  logic [$clog2(ROB_DEPTH)-1:0]           retire_idx,
  input  logic                                   flush,
  input  logic [$clog2(ROB_DEPTH)-1:0]           head_idx,
  output logic                                   head_valid,
  output logic                                   head_done,
  output logic                                   head_mispred,
  output logic [$clog2(util_pkg::RHT_DEPTH)-1:0] head_rht_id,
  output logic                                   ex_hit_valid,
  output logic                                   ex_hit_done
);
  import util_pkg::*;

  rob_entry_t entries_q [ROB_DEPTH];
  rob_entry_t entries_d [ROB_DEPTH];

  always_comb begin
    // NOTE: every combinational output starts from a full default so no path infers a latch.
    entries_d = entries_q;
    if (ex_we) begin
      entries_d[ex_idx].done    = 1'b1;
      entries_d[ex_idx].mispred = ex_mispred & entries_q[ex_idx].br;
    end
    if (retire_we) begin
      entries_d[retire_idx].valid = 1'b0;
    end
    if (alloc_we) begin
      entries_d[alloc_idx] = alloc_entry;
    end
    // Flush is applied last so a late completion cannot resurrect a discarded entry.
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the table is small and flop-based, so reset clears every field and no X
    // from done/mispred can leak into the commit decision after reuse.
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      entries_q <= entries_d;
    end
  end

  always_comb begin
    head_valid   = entries_q[head_idx].valid;
    head_done    = entries_q[head_idx].done;
    head_mispred = entries_q[head_idx].mispred;
    head_rht_id  = entries_q[head_idx].rht_id;
    ex_hit_valid = entries_q[ex_idx].valid;
    ex_hit_done  = entries_q[ex_idx].done;
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order retirement for the renaming unit: tracks allocated ROB ids, collects completions,
// returns wb_en, and runs branch-mispredict recovery (request, wait on rec_busy, flush).
module rob_commit_ctrl #(
  parameter int ROB_DEPTH = util_pkg::ROB_DEPTH,
  parameter int RHT_DEPTH = util_pkg::RHT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0] alloc_rob_id,
  input  logic [$clog2(RHT_DEPTH)-1:0] alloc_rht_id,
  input  logic                         alloc_br,
  input  logic                         ex_valid,
  input  logic [$clog2(ROB_DEPTH)-1:0] ex_rob_id,
  input  logic                         ex_mispred,
  input  logic                         rec_busy,
  output logic                         stall_o,
  output logic                         wb_en,
  output logic                         rec_en,
  output logic [$clog2(ROB_DEPTH)-1:0] rec_rob_id,
  output logic [$clog2(RHT_DEPTH)-1:0] rec_rht_id,
  output logic                         commit_en,
  output logic [$clog2(ROB_DEPTH)-1:0] commit_rob_id,
  output logic                         rob_full,
  output logic                         rob_empty,
  output logic                         err_o
);
  import util_pkg::*;

  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam int RHT_W = $clog2(RHT_DEPTH);
  localparam logic [ROB_W:0] PTR_ONE = 1;

  // Pointers carry one extra wrap bit above the entry index.
  logic [ROB_W:0]   head_q, head_d;
  logic [ROB_W:0]   tail_q, tail_d;
  rec_state_t       state_q, state_d;
  logic             err_q, err_d;
  logic             wb_en_q, wb_en_d;
  logic             rec_en_q, rec_en_d;
  logic [ROB_W-1:0] rec_rob_id_q, rec_rob_id_d;
  logic [RHT_W-1:0] rec_rht_id_q, rec_rht_id_d;
  logic             commit_en_q, commit_en_d;
  logic [ROB_W-1:0] commit_rob_id_q, commit_rob_id_d;

  logic             head_valid, head_done, head_mispred;
  logic [RHT_W-1:0] head_rht_id;
  logic             ex_hit_valid, ex_hit_done;
  logic             full, empty, stall;
  logic             alloc_acc, ex_acc, head_ready;
  logic             retire_we, flush;
  rob_entry_t       alloc_entry;

  rob_entry_table #(
    .ROB_DEPTH(ROB_DEPTH)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .alloc_we    (alloc_acc),
    .alloc_idx   (tail_q[ROB_W-1:0]),
    .alloc_entry (alloc_entry),
    .ex_we       (ex_acc),
    .ex_idx      (ex_rob_id),
    .ex_mispred  (ex_mispred),
    .retire_we   (retire_we),
    .retire_idx  (head_q[ROB_W-1:0]),
    .flush       (flush),
    .head_idx    (head_q[ROB_W-1:0]),
    .head_valid  (head_valid),
    .head_done   (head_done),
    .head_mispred(head_mispred),
    .head_rht_id (head_rht_id),
    .ex_hit_valid(ex_hit_valid),
    .ex_hit_done (ex_hit_done)
  );

  always_comb begin
    full       = (head_q[ROB_W-1:0] == tail_q[ROB_W-1:0]) && (head_q[ROB_W] != tail_q[ROB_W]);
    empty      = (head_q == tail_q);
    stall      = full || (state_q != IDLE);
    alloc_acc  = alloc_valid && !stall;
    ex_acc     = ex_valid && ex_hit_valid && !ex_hit_done;
    head_ready = head_valid && head_done;

    alloc_entry         = '0;
    alloc_entry.valid   = 1'b1;
    alloc_entry.br      = alloc_br;
    alloc_entry.rht_id  = alloc_rht_id;
  end

  always_comb begin
    state_d         = state_q;
    head_d          = head_q;
    tail_d          = tail_q;
    err_d           = err_q;
    wb_en_d         = ex_acc;
    rec_en_d        = 1'b0;
    rec_rob_id_d    = rec_rob_id_q;
    rec_rht_id_d    = rec_rht_id_q;
    commit_en_d     = 1'b0;
    commit_rob_id_d = commit_rob_id_q;
    retire_we       = 1'b0;
    flush           = 1'b0;

    if (alloc_acc) begin
      tail_d = tail_q + PTR_ONE;
      if (alloc_rob_id != tail_q[ROB_W-1:0]) err_d = 1'b1;
    end
    if (alloc_valid && stall) err_d = 1'b1;
    if (ex_valid && !ex_acc)  err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (head_ready && head_mispred) begin
          state_d      = REC_REQ;
          rec_en_d     = 1'b1;
          rec_rob_id_d = head_q[ROB_W-1:0];
          rec_rht_id_d = head_rht_id;
        end else if (head_ready) begin
          commit_en_d     = 1'b1;
          commit_rob_id_d = head_q[ROB_W-1:0];
          head_d          = head_q + PTR_ONE;
          retire_we       = 1'b1;
        end
      end
      REC_REQ: state_d = REC_WAIT;
      // rec_busy is only meaningful from the cycle after rec_en, i.e. from REC_WAIT on.
      REC_WAIT: begin
        if (!rec_busy) state_d = FLUSH;
      end
      FLUSH: begin
        commit_en_d     = 1'b1;
        commit_rob_id_d = head_q[ROB_W-1:0];
        head_d          = head_q + PTR_ONE;
        tail_d          = head_q + PTR_ONE;
        flush           = 1'b1;
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q         <= IDLE;
      head_q          <= '0;
      tail_q          <= '0;
      err_q           <= 1'b0;
      wb_en_q         <= 1'b0;
      rec_en_q        <= 1'b0;
      rec_rob_id_q    <= '0;
      rec_rht_id_q    <= '0;
      commit_en_q     <= 1'b0;
      commit_rob_id_q <= '0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      err_q           <= err_d;
      wb_en_q         <= wb_en_d;
      rec_en_q        <= rec_en_d;
      rec_rob_id_q    <= rec_rob_id_d;
      rec_rht_id_q    <= rec_rht_id_d;
      commit_en_q     <= commit_en_d;
      commit_rob_id_q <= commit_rob_id_d;
    end
  end

  assign stall_o       = stall;
  assign wb_en         = wb_en_q;
  assign rec_en        = rec_en_q;
  assign rec_rob_id    = rec_rob_id_q;
  assign rec_rht_id    = rec_rht_id_q;
  assign commit_en     = commit_en_q;
  assign commit_rob_id = commit_rob_id_q;
  assign rob_full      = full;
  assign rob_empty     = empty;
  assign err_o         = err_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl: stimulus pushes expected wb/commit/recovery events into
// queues and a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_rob_commit_ctrl;

  localparam int ROB_W = 4;
  localparam int RHT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             alloc_valid, alloc_br, ex_valid, ex_mispred, rec_busy;
  logic [ROB_W-1:0] alloc_rob_id, ex_rob_id;
  logic [RHT_W-1:0] alloc_rht_id;
  logic             stall_o, wb_en, rec_en, commit_en, rob_full, rob_empty, err_o;
  logic [ROB_W-1:0] rec_rob_id, commit_rob_id;
  logic [RHT_W-1:0] rec_rht_id;

  int n_checks = 0;
  int n_errors = 0;
  int exp_wb_q[$];
  int exp_commit_q[$];
  int exp_rec_rob_q[$];
  int exp_rec_rht_q[$];

  always #5 clk = ~clk;

  rob_commit_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_rob_id (alloc_rob_id),
    .alloc_rht_id (alloc_rht_id),
    .alloc_br     (alloc_br),
    .ex_valid     (ex_valid),
    .ex_rob_id    (ex_rob_id),
    .ex_mispred   (ex_mispred),
    .rec_busy     (rec_busy),
    .stall_o      (stall_o),
    .wb_en        (wb_en),
    .rec_en       (rec_en),
    .rec_rob_id   (rec_rob_id),
    .rec_rht_id   (rec_rht_id),
    .commit_en    (commit_en),
    .commit_rob_id(commit_rob_id),
    .rob_full     (rob_full),
    .rob_empty    (rob_empty),
    .err_o        (err_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (wb_en === 1'b1) begin
      check("wb_en expected", int'(exp_wb_q.size() > 0), 1);
      if (exp_wb_q.size() > 0) void'(exp_wb_q.pop_front());
    end
    if (commit_en === 1'b1) begin
      check("commit expected", int'(exp_commit_q.size() > 0), 1);
      if (exp_commit_q.size() > 0) check("commit_rob_id", int'(commit_rob_id), exp_commit_q.pop_front());
    end
    if (rec_en === 1'b1) begin
      check("rec expected", int'(exp_rec_rob_q.size() > 0), 1);
      if (exp_rec_rob_q.size() > 0) begin
        check("rec_rob_id", int'(rec_rob_id), exp_rec_rob_q.pop_front());
        check("rec_rht_id", int'(rec_rht_id), exp_rec_rht_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid  = 1'b0;
    alloc_rob_id = '0;
    alloc_rht_id = '0;
    alloc_br     = 1'b0;
    ex_valid     = 1'b0;
    ex_rob_id    = '0;
    ex_mispred   = 1'b0;
    rec_busy     = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " stall_o"}, int'(stall_o), 0);
    check({tag, " wb_en"}, int'(wb_en), 0);
    check({tag, " rec_en"}, int'(rec_en), 0);
    check({tag, " rec_rob_id"}, int'(rec_rob_id), 0);
    check({tag, " rec_rht_id"}, int'(rec_rht_id), 0);
    check({tag, " commit_en"}, int'(commit_en), 0);
    check({tag, " commit_rob_id"}, int'(commit_rob_id), 0);
    check({tag, " rob_full"}, int'(rob_full), 0);
    check({tag, " rob_empty"}, int'(rob_empty), 1);
    check({tag, " err_o"}, int'(err_o), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    check_reset_state(tag);
    rst = 1'b0;
  endtask

  task automatic alloc(input int id, input logic br, input int rht);
    alloc_valid  = 1'b1;
    alloc_rob_id = ROB_W'(id);
    alloc_br     = br;
    alloc_rht_id = RHT_W'(rht);
    tick();
    alloc_valid  = 1'b0;
    alloc_br     = 1'b0;
  endtask

  task automatic ex(input int id, input logic mis);
    ex_valid   = 1'b1;
    ex_rob_id  = ROB_W'(id);
    ex_mispred = mis;
    tick();
    ex_valid   = 1'b0;
    ex_mispred = 1'b0;
  endtask

  // Bounded wait for all outstanding expectations; leftovers count as a failure.
  task automatic wait_drain(input string tag, input int max_cycles);
    int c = 0;
    while ((exp_wb_q.size() + exp_commit_q.size() + exp_rec_rob_q.size()) != 0 && c < max_cycles) begin
      tick();
      c++;
    end
    tick();
    check({tag, " pending events"}, exp_wb_q.size() + exp_commit_q.size() + exp_rec_rob_q.size(), 0);
  endtask

  initial begin
    clear_inputs();
    do_reset("reset");

    // Out-of-order completion, in-order consecutive commits.
    for (int i = 0; i < 3; i++) alloc(i, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      exp_wb_q.push_back(1);
      exp_commit_q.push_back(i);
    end
    ex(2, 1'b0);
    ex(0, 1'b0);
    ex(1, 1'b0);
    check("t1 commit c0", int'(commit_en), 1);
    tick();
    check("t1 commit c1", int'(commit_en), 1);
    tick();
    check("t1 commit c2", int'(commit_en), 1);
    tick();
    check("t1 commit done", int'(commit_en), 0);
    check("t1 rob_empty", int'(rob_empty), 1);
    wait_drain("t1", 20);
    check("t1 err_o", int'(err_o), 0);

    // Mispredicted branch id 3 (rht 5) with ids 4..7 live.
    alloc(3, 1'b1, 5);
    for (int i = 4; i < 8; i++) alloc(i, 1'b0, 0);
    exp_wb_q.push_back(1);
    exp_rec_rob_q.push_back(3);
    exp_rec_rht_q.push_back(5);
    exp_commit_q.push_back(3);
    ex(3, 1'b1);
    tick();
    check("rec rec_en", int'(rec_en), 1);
    check("rec stall REC_REQ", int'(stall_o), 1);
    exp_wb_q.push_back(1);
    rec_busy = 1'b1;
    ex(5, 1'b0);
    check("rec rec_en pulse", int'(rec_en), 0);
    for (int i = 0; i < 3; i++) begin
      check("rec stall REC_WAIT", int'(stall_o), 1);
      tick();
    end
    check("rec stall busy end", int'(stall_o), 1);
    rec_busy = 1'b0;
    tick();
    check("rec stall FLUSH", int'(stall_o), 1);
    check("rec no early commit", int'(commit_en), 0);
    tick();
    check("rec flush commit_en", int'(commit_en), 1);
    check("rec flush commit id", int'(commit_rob_id), 3);
    check("rec rob_empty", int'(rob_empty), 1);
    check("rec stall released", int'(stall_o), 0);
    wait_drain("rec", 20);
    check("rec err_o", int'(err_o), 0);
    // head=tail=4 after flush: next alloc must be id 4 without error.
    alloc(4, 1'b0, 0);
    check("rec tail id4 err_o", int'(err_o), 0);

    // ex to an unallocated id.
    do_reset("reset2");
    ex(9, 1'b0);
    check("err unalloc err_o", int'(err_o), 1);
    check("err unalloc stall", int'(stall_o), 0);
    check("err unalloc empty", int'(rob_empty), 1);
    tick();

    // ex to an already-done entry.
    do_reset("reset3");
    alloc(0, 1'b0, 0);
    alloc(1, 1'b0, 0);
    exp_wb_q.push_back(1);
    ex(1, 1'b0);
    check("err done before", int'(err_o), 0);
    ex(1, 1'b0);
    check("err done err_o", int'(err_o), 1);
    check("err done stall", int'(stall_o), 0);
    check("err done empty", int'(rob_empty), 0);
    exp_wb_q.push_back(1);
    exp_commit_q.push_back(0);
    exp_commit_q.push_back(1);
    ex(0, 1'b0);
    wait_drain("err done", 20);
    check("err done drained", int'(rob_empty), 1);

    // Fill to full, then an alloc while stalled.
    do_reset("reset4");
    for (int i = 0; i < 16; i++) alloc(i, 1'b0, 0);
    check("full rob_full", int'(rob_full), 1);
    check("full stall_o", int'(stall_o), 1);
    check("full err_o", int'(err_o), 0);
    alloc(0, 1'b0, 0);
    check("full17 err_o", int'(err_o), 1);
    check("full17 rob_full", int'(rob_full), 1);
    check("full17 rob_empty", int'(rob_empty), 0);

    // 40 instructions streaming through, ids wrapping twice.
    do_reset("reset5");
    for (int k = 0; k <= 40; k++) begin
      alloc_valid  = (k < 40);
      alloc_rob_id = ROB_W'(k % 16);
      ex_valid     = (k > 0);
      ex_rob_id    = ROB_W'((k + 15) % 16);
      if (k > 0) begin
        exp_wb_q.push_back(1);
        exp_commit_q.push_back((k - 1) % 16);
      end
      tick();
    end
    clear_inputs();
    wait_drain("wrap", 40);
    check("wrap rob_empty", int'(rob_empty), 1);
    check("wrap err_o", int'(err_o), 0);

    // Reset while waiting on rec_busy.
    do_reset("reset6");
    alloc(0, 1'b1, 2);
    exp_wb_q.push_back(1);
    exp_rec_rob_q.push_back(0);
    exp_rec_rht_q.push_back(2);
    ex(0, 1'b1);
    tick();
    check("rstrec rec_en", int'(rec_en), 1);
    rec_busy = 1'b1;
    tick();
    tick();
    check("rstrec stall", int'(stall_o), 1);
    rst = 1'b1;
    tick();
    check_reset_state("rstrec");
    rst = 1'b0;
    rec_busy = 1'b0;
    repeat (6) tick();
    check("rstrec empty after", int'(rob_empty), 1);
    check("rstrec stall after", int'(stall_o), 0);
    wait_drain("rstrec", 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
